round_robin_arbiter_n_requests: RTL

ROUND_ROBIN_ARBITER_N_REQUESTS -- requirements
Module: round_robin_arbiter_n_requests

---
 rtl/round_robin_arbiter_n_requests.sv | 99 +++++++++
 1 files changed

// File: rtl/round_robin_arbiter_n_requests.sv
// Round-robin arbiter over N requesters with a bounded ownership hold.
// Grants are combinational from requests and the registered pointer/owner state.
module round_robin_arbiter_n_requests #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grants,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]     owner_mask;
  logic             others_req;
  logic             hold_ok;
  logic [IdxW-1:0]  rot_idx;
  logic             rot_found;
  logic             gnt_any;
  logic [IdxW-1:0]  gnt_idx;

  // First requesting index scanning upward from ptr, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    rot_idx   = '0;
    rot_found = 1'b0;
    for (int unsigned o = 0; o < N; o++) begin
      cand = 32'(ptr_q) + o;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!rot_found && requests[IdxW'(cand)]) begin
        rot_found = 1'b1;
        rot_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    others_req          = |(requests & ~owner_mask);
    // hold_cnt never exceeds HoldMax, so inequality means "hold budget left".
    hold_ok = owner_valid_q && requests[owner_q] && ((hold_cnt_q != HoldMax) || !others_req);

    gnt_any = rst_n && (|requests);
    gnt_idx = hold_ok ? owner_q : rot_idx;

    grants = '0;
    if (gnt_any) begin
      grants[gnt_idx] = 1'b1;
    end
    grant_valid = gnt_any;
    grant_idx   = gnt_any ? gnt_idx : '0;
  end

  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = 1'b0;
    hold_cnt_d    = '0;
    if (gnt_any) begin
      ptr_d         = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
      owner_d       = gnt_idx;
      owner_valid_d = 1'b1;
      if (owner_valid_q && (gnt_idx == owner_q)) begin
        hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

endmodule
